// File: rtl/uart_alu_ctrl_if.sv
// Bundles the UART receive/transmit handshakes and the ALU operand/result bus
// between the frame controller (master) and the surrounding UART/ALU logic (slave).
interface uart_alu_ctrl_if #(
    parameter int NB_DATA   = 8,
    parameter int NB_ALU_OP = 6
);
    logic [NB_DATA-1:0]   i_rx_data;
    logic                 i_rx_done;
    logic                 i_tx_done;
    logic [NB_DATA-1:0]   i_alu_res;
    logic                 i_alu_zero;
    logic                 i_alu_overflow;
    logic                 o_tx_start;
    logic [NB_DATA-1:0]   o_tx_data;
    logic [NB_DATA-1:0]   o_alu_a;
    logic [NB_DATA-1:0]   o_alu_b;
    logic [NB_ALU_OP-1:0] o_alu_op;
    logic                 o_busy;
    logic                 o_drop;
    logic                 o_timeout;

    modport master (
        input  i_rx_data, i_rx_done, i_tx_done, i_alu_res, i_alu_zero, i_alu_overflow,
        output o_tx_start, o_tx_data, o_alu_a, o_alu_b, o_alu_op, o_busy, o_drop, o_timeout
    );

    modport slave (
        output i_rx_data, i_rx_done, i_tx_done, i_alu_res, i_alu_zero, i_alu_overflow,
        input  o_tx_start, o_tx_data, o_alu_a, o_alu_b, o_alu_op, o_busy, o_drop, o_timeout
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// Collects A, B, opcode bytes from a UART, runs the external ALU, returns result and flag bytes.
// Optional inter-byte timeout is compiled in with the macro UART_ALU_TIMEOUT_EN.
module uart_alu_ctrl #(
    parameter int NB_DATA        = 8,
    parameter int NB_ALU_OP      = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic            i_clk,
    input  logic            i_reset,
    uart_alu_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG
    } state_t;

    state_t               state, state_next;
    logic [NB_DATA-1:0]   alu_a, alu_b, result, flag;
    logic [NB_ALU_OP-1:0] alu_op;
    logic                 accept_a, accept_b, accept_op;
    logic                 drop;
    logic                 timeout_hit;

    if (NB_ALU_OP > NB_DATA || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uart_alu_ctrl: NB_ALU_OP must not exceed NB_DATA and TIMEOUT_CYCLES must be >= 2");
    end

`ifdef UART_ALU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             waiting;

    assign waiting     = (state == WAIT_B) || (state == WAIT_OP);
    // A byte arriving on the last count wins over the timeout.
    assign timeout_hit = waiting && !bus.i_rx_done && (cnt == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (waiting && !bus.i_rx_done && !timeout_hit) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept_a   = 1'b0;
        accept_b   = 1'b0;
        accept_op  = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_rx_done) begin
                    accept_a   = 1'b1;
                    state_next = WAIT_B;
                end
            end
            WAIT_B: begin
                if (bus.i_rx_done) begin
                    accept_b   = 1'b1;
                    state_next = WAIT_OP;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            WAIT_OP: begin
                if (bus.i_rx_done) begin
                    accept_op  = 1'b1;
                    state_next = EXEC;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            EXEC: begin
                drop       = bus.i_rx_done;
                state_next = SEND_RES;
            end
            SEND_RES: begin
                drop       = bus.i_rx_done;
                state_next = WAIT_RES;
            end
            WAIT_RES: begin
                drop = bus.i_rx_done;
                if (bus.i_tx_done) state_next = SEND_FLG;
            end
            SEND_FLG: begin
                drop       = bus.i_rx_done;
                state_next = WAIT_FLG;
            end
            WAIT_FLG: begin
                drop = bus.i_rx_done;
                if (bus.i_tx_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            result <= '0;
            flag   <= '0;
        end else begin
            if (accept_a)  alu_a  <= bus.i_rx_data;
            if (accept_b)  alu_b  <= bus.i_rx_data;
            if (accept_op) alu_op <= bus.i_rx_data[NB_ALU_OP-1:0];
            if (state == EXEC) begin
                result <= bus.i_alu_res;
                flag   <= NB_DATA'({bus.i_alu_overflow, bus.i_alu_zero});
            end
        end
    end

    // Transmit byte is selected by phase so it stays stable until the transmitter finishes.
    assign bus.o_tx_data  = ((state == SEND_FLG) || (state == WAIT_FLG)) ? flag : result;
    assign bus.o_tx_start = (state == SEND_RES) || (state == SEND_FLG);
    assign bus.o_alu_a    = alu_a;
    assign bus.o_alu_b    = alu_b;
    assign bus.o_alu_op   = alu_op;
    assign bus.o_busy     = (state != IDLE);
    assign bus.o_drop     = drop;
    assign bus.o_timeout  = timeout_hit;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl: table of frames plus hand sequences for drop, reset and timeout.
module tb_uart_alu_ctrl;
    localparam int NB_DATA        = 8;
    localparam int NB_ALU_OP      = 6;
    localparam int TIMEOUT_CYCLES = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   drop_cnt = 0;
    int   timeout_cnt = 0;
    int   back2back = 0;
    logic prev_start = 1'b0, prev_drop = 1'b0, prev_to = 1'b0;

    uart_alu_ctrl_if #(.NB_DATA(NB_DATA), .NB_ALU_OP(NB_ALU_OP)) bus ();

    uart_alu_ctrl #(
        .NB_DATA(NB_DATA), .NB_ALU_OP(NB_ALU_OP), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .i_clk(clk), .i_reset(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference ALU: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25.
    logic [7:0] alu_res_m;
    logic       alu_ovf_m;
    always_comb begin
        alu_res_m = '0;
        alu_ovf_m = 1'b0;
        case (bus.o_alu_op)
            6'h20: begin
                alu_res_m = bus.o_alu_a + bus.o_alu_b;
                alu_ovf_m = (bus.o_alu_a[7] == bus.o_alu_b[7]) && (alu_res_m[7] != bus.o_alu_a[7]);
            end
            6'h22: begin
                alu_res_m = bus.o_alu_a - bus.o_alu_b;
                alu_ovf_m = (bus.o_alu_a[7] != bus.o_alu_b[7]) && (alu_res_m[7] != bus.o_alu_a[7]);
            end
            6'h24: alu_res_m = bus.o_alu_a & bus.o_alu_b;
            6'h25: alu_res_m = bus.o_alu_a | bus.o_alu_b;
            default: ;
        endcase
    end
    assign bus.i_alu_res      = alu_res_m;
    assign bus.i_alu_zero     = (alu_res_m == 8'h00);
    assign bus.i_alu_overflow = alu_ovf_m;

    always @(negedge clk) begin
        #2;
        if (bus.o_drop) drop_cnt++;
        if (bus.o_timeout) timeout_cnt++;
        if ((bus.o_drop && prev_drop) || (bus.o_tx_start && prev_start) || (bus.o_timeout && prev_to))
            back2back++;
        prev_drop  = bus.o_drop;
        prev_start = bus.o_tx_start;
        prev_to    = bus.o_timeout;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
        #1;
    endtask

    task automatic wait_start(output logic [7:0] d, output int lat);
        lat = -1;
        d   = '0;
        for (int i = 0; i < 50; i++) begin
            if (bus.o_tx_start) begin
                lat = i;
                d   = bus.o_tx_data;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic finish_tx(input logic [7:0] d, output bit hold_ok);
        hold_ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (bus.o_tx_start || bus.o_tx_data !== d) hold_ok = 1'b0;
        end
        @(negedge clk);
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        #1;
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             output logic [7:0] r0, output logic [7:0] r1,
                             output int lat0, output int lat1, output bit hold_ok);
        bit h0, h1;
        rx_byte(a);
        rx_byte(b);
        rx_byte(op);
        wait_start(r0, lat0);
        finish_tx(r0, h0);
        wait_start(r1, lat1);
        finish_tx(r1, h1);
        hold_ok = h0 && h1;
    endtask

    typedef struct {
        logic [7:0] a, b, op_byte;
        logic [5:0] exp_op;
        logic [7:0] exp_res, exp_flag;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[8];
        logic [7:0] r0, r1;
        int         lat0, lat1, d0, t0, idx;
        bit         hold;

        vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 8'h00};
        vecs[1] = '{8'h03, 8'h03, 8'h22, 6'h22, 8'h00, 8'h01};
        vecs[2] = '{8'h01, 8'h02, 8'hE0, 6'h20, 8'h03, 8'h00};
        vecs[3] = '{8'h7F, 8'h01, 8'h20, 6'h20, 8'h80, 8'h02};
        vecs[4] = '{8'h80, 8'h01, 8'h22, 6'h22, 8'h7F, 8'h02};
        vecs[5] = '{8'hF0, 8'h0F, 8'h24, 6'h24, 8'h00, 8'h01};
        vecs[6] = '{8'hF0, 8'h0F, 8'h25, 6'h25, 8'hFF, 8'h00};
        vecs[7] = '{8'hFF, 8'h01, 8'h20, 6'h20, 8'h00, 8'h01};

        bus.i_rx_data = '0;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("reset busy",     32'(bus.o_busy),     32'h0);
        check("reset tx_start", 32'(bus.o_tx_start), 32'h0);
        check("reset tx_data",  32'(bus.o_tx_data),  32'h0);
        check("reset alu_a",    32'(bus.o_alu_a),    32'h0);
        check("reset alu_b",    32'(bus.o_alu_b),    32'h0);
        check("reset alu_op",   32'(bus.o_alu_op),   32'h0);
        check("reset drop",     32'(bus.o_drop),     32'h0);
        check("reset timeout",  32'(bus.o_timeout),  32'h0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].a, vecs[i].b, vecs[i].op_byte, r0, r1, lat0, lat1, hold);
            check($sformatf("v%0d alu_a", i),  32'(bus.o_alu_a),  32'(vecs[i].a));
            check($sformatf("v%0d alu_b", i),  32'(bus.o_alu_b),  32'(vecs[i].b));
            check($sformatf("v%0d alu_op", i), 32'(bus.o_alu_op), 32'(vecs[i].exp_op));
            check($sformatf("v%0d result", i), 32'(r0),           32'(vecs[i].exp_res));
            check($sformatf("v%0d flag", i),   32'(r1),           32'(vecs[i].exp_flag));
            check($sformatf("v%0d latency", i), 32'(lat0), 32'd1);
            check($sformatf("v%0d flag start", i), 32'(lat1), 32'd0);
            check($sformatf("v%0d hold", i),   32'(hold),         32'h1);
            check($sformatf("v%0d idle", i),   32'(bus.o_busy),   32'h0);
        end

        // Extra byte while the result is being transmitted.
        d0 = drop_cnt;
        rx_byte(8'h05);
        rx_byte(8'h03);
        rx_byte(8'h20);
        wait_start(r0, lat0);
        @(negedge clk);
        bus.i_rx_data = 8'h77;
        bus.i_rx_done = 1'b1;
        #1;
        check("drop pulse", 32'(bus.o_drop), 32'h1);
        @(negedge clk);
        bus.i_rx_done = 1'b0;
        #1;
        check("drop single", 32'(bus.o_drop), 32'h0);
        check("drop busy", 32'(bus.o_busy), 32'h1);
        finish_tx(r0, hold);
        wait_start(r1, lat1);
        finish_tx(r1, hold);
        check("drop result", 32'(r0), 32'h08);
        check("drop flag", 32'(r1), 32'h00);
        check("drop count", 32'(drop_cnt - d0), 32'd1);
        check("drop idle", 32'(bus.o_busy), 32'h0);
        check("drop alu_a kept", 32'(bus.o_alu_a), 32'h05);

        // tx_done in IDLE must not start anything.
        @(negedge clk);
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        #1;
        check("stray tx_done busy", 32'(bus.o_busy), 32'h0);
        check("stray tx_done start", 32'(bus.o_tx_start), 32'h0);

        // Reset while waiting for the transmitter.
        rx_byte(8'h11);
        rx_byte(8'h22);
        rx_byte(8'h20);
        wait_start(r0, lat0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midreset busy", 32'(bus.o_busy), 32'h0);
        check("midreset tx_start", 32'(bus.o_tx_start), 32'h0);
        check("midreset alu_a", 32'(bus.o_alu_a), 32'h0);
        check("midreset tx_data", 32'(bus.o_tx_data), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        run_frame(8'h01, 8'h01, 8'h20, r0, r1, lat0, lat1, hold);
        check("post reset alu_a", 32'(bus.o_alu_a), 32'h01);
        check("post reset result", 32'(r0), 32'h02);
        check("post reset flag", 32'(r1), 32'h00);

`ifdef UART_ALU_TIMEOUT_EN
        t0 = timeout_cnt;
        rx_byte(8'h42);
        idx = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.o_timeout) begin
                idx = i;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("timeout cycle", 32'(idx), 32'd15);
        @(negedge clk);
        #1;
        check("timeout idle", 32'(bus.o_busy), 32'h0);
        check("timeout once", 32'(timeout_cnt - t0), 32'd1);
        run_frame(8'h09, 8'h01, 8'h20, r0, r1, lat0, lat1, hold);
        check("timeout next A", 32'(bus.o_alu_a), 32'h09);
        check("timeout next result", 32'(r0), 32'h0A);

        // Byte on the final count must be accepted.
        t0 = timeout_cnt;
        rx_byte(8'h42);
        repeat (14) @(negedge clk);
        rx_byte(8'h01);
        check("priority no timeout", 32'(timeout_cnt - t0), 32'd0);
        check("priority busy", 32'(bus.o_busy), 32'h1);
        rx_byte(8'h20);
        wait_start(r0, lat0);
        finish_tx(r0, hold);
        wait_start(r1, lat1);
        finish_tx(r1, hold);
        check("priority result", 32'(r0), 32'h43);
        check("priority alu_b", 32'(bus.o_alu_b), 32'h01);
`else
        t0  = timeout_cnt;
        idx = 0;
        rx_byte(8'h42);
        repeat (40) @(negedge clk);
        #1;
        check("no timeout busy", 32'(bus.o_busy), 32'h1);
        check("no timeout pulse", 32'(timeout_cnt - t0 + idx), 32'd0);
        rx_byte(8'h01);
        rx_byte(8'h20);
        wait_start(r0, lat0);
        finish_tx(r0, hold);
        wait_start(r1, lat1);
        finish_tx(r1, hold);
        check("late frame result", 32'(r0), 32'h43);
`endif

        @(negedge clk);
        #3;
        check("no back-to-back pulses", 32'(back2back), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_alu_ctrl.md
UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, data byte and ALU operand/result width.
REQ-002 SHALL have parameter NB_ALU_OP, default 6, ALU opcode width (NB_ALU_OP <= NB_DATA).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, inter-byte timeout in i_clk cycles (used only with UART_ALU_TIMEOUT_EN).
REQ-004 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_rx_data  input  NB_DATA  received byte, valid when i_rx_done=1.
REQ-007 SHALL have port i_rx_done  input  1  one-cycle pulse from the receiver, byte available.
REQ-008 SHALL have port i_tx_done  input  1  one-cycle pulse from the transmitter, byte finished.
REQ-009 SHALL have port i_alu_res  input  NB_DATA  combinational ALU result.
REQ-010 SHALL have port i_alu_zero  input  1  ALU zero flag.
REQ-011 SHALL have port i_alu_overflow  input  1  ALU overflow flag.
REQ-012 SHALL have port o_tx_start  output  1  one-cycle transmit request.
REQ-013 SHALL have port o_tx_data  output  NB_DATA  byte to transmit, held stable from o_tx_start until i_tx_done.
REQ-014 SHALL have ports o_alu_a, o_alu_b  output  NB_DATA, and o_alu_op  output  NB_ALU_OP: registered ALU operands and opcode.
REQ-015 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port o_drop  output  1  one-cycle pulse when a received byte is discarded.
REQ-017 SHALL have port o_timeout  output  1  one-cycle pulse on inter-byte timeout.

Function
REQ-018 SHALL implement states IDLE, WAIT_B, WAIT_OP, EXEC, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG.
REQ-019 IDLE + i_rx_done: o_alu_a <= i_rx_data, go to WAIT_B; WAIT_B + i_rx_done: o_alu_b <= i_rx_data, go to WAIT_OP.
REQ-020 WAIT_OP + i_rx_done: o_alu_op <= i_rx_data[NB_ALU_OP-1:0], upper bits ignored, go to EXEC.
REQ-021 EXEC lasts exactly one cycle: result register <= i_alu_res, flag register <= {zeros, i_alu_overflow, i_alu_zero}, go to SEND_RES.
REQ-022 SEND_RES: o_tx_start=1 for exactly one cycle, o_tx_data=result, go to WAIT_RES; WAIT_RES + i_tx_done: go to SEND_FLG.
REQ-023 SEND_FLG: o_tx_start=1 for one cycle, o_tx_data=flag byte, go to WAIT_FLG; WAIT_FLG + i_tx_done: go to IDLE.
REQ-024 Latency: first o_tx_start is asserted 2 cycles after the cycle with the opcode i_rx_done.
REQ-025 i_rx_done in EXEC, SEND_*, WAIT_RES or WAIT_FLG: byte discarded, o_drop=1 that cycle, state unaffected.
REQ-026 i_tx_done outside WAIT_RES/WAIT_FLG: ignored.
REQ-027 o_alu_a, o_alu_b, o_alu_op SHALL hold their last values until overwritten by a new frame.
REQ-028 o_tx_start, o_drop, o_timeout SHALL never be high for two consecutive cycles.

Reset
REQ-029 i_reset=1 SHALL immediately force state IDLE and all outputs, result, flag and timeout counter to 0, including mid-frame and mid-transmission.
REQ-030 After reset release, the first i_rx_done SHALL be treated as operand A.

Configuration
REQ-031 Macro UART_ALU_TIMEOUT_EN defined: counter clears on each accepted byte, counts in WAIT_B/WAIT_OP; on reaching TIMEOUT_CYCLES-1 without i_rx_done, go to IDLE and pulse o_timeout; i_rx_done in that same cycle SHALL take priority (byte accepted, no timeout).
REQ-032 Macro undefined: no counter is instantiated, WAIT_B/WAIT_OP wait indefinitely, o_timeout tied 0.

Verification
REQ-033 Bytes 0x05, 0x03, 0x20 (ADD) with ALU model -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=6'h20; transmitted 0x08 then 0x00.
REQ-034 Bytes 0x03, 0x03, 0x22 (SUB) -> transmitted 0x00 then 0x01 (zero flag).
REQ-035 Opcode byte 0xE0 -> o_alu_op=6'h20.
REQ-036 Extra i_rx_done pulse during WAIT_RES -> o_drop pulses once, transmitted bytes unchanged, state returns to IDLE after the second i_tx_done.
REQ-037 i_reset pulse while in WAIT_RES -> o_busy=0, o_tx_start=0, o_alu_a=0 immediately; next frame 0x01, 0x01, 0x20 transmits 0x02, 0x00.
REQ-038 With UART_ALU_TIMEOUT_EN and TIMEOUT_CYCLES=16: one byte, then 16 idle cycles -> o_timeout pulses once, o_busy=0; next byte is captured as A.
